// File: rtl/proj_switch_mux.sv
// Sequenced multi-project input multiplexer: routes clock, reset and input bus to one
// project, running a drain / park / reset handover whenever the selection changes.
module proj_switch_mux #(
    parameter int NUM_DESIGNS  = 8,
    parameter int SEL_BITS     = 3,
    parameter int INPUT_BITS   = 8,
    parameter int DRAIN_CYCLES = 2,
    parameter int RST_CYCLES   = 4
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [SEL_BITS-1:0]               sel,
    input  logic                              rst_n_in,
    input  logic [INPUT_BITS-1:0]             in,
    output logic [NUM_DESIGNS-1:0]            proj_clk,
    output logic [NUM_DESIGNS-1:0]            proj_rst_n,
    output logic [NUM_DESIGNS*INPUT_BITS-1:0] proj_in,
    output logic [SEL_BITS-1:0]               active_sel,
    output logic                              busy,
    output logic [1:0]                        dbg_state
);

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_SWITCH = 2'd2,
        ST_RESET  = 2'd3
    } state_t;

    localparam int CNT_MAX = ((DRAIN_CYCLES > RST_CYCLES) ? DRAIN_CYCLES : RST_CYCLES) - 1;
    localparam int CNT_W   = (CNT_MAX < 1) ? 1 : $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0]    DRAIN_LOAD = CNT_W'(DRAIN_CYCLES - 1);
    localparam logic [CNT_W-1:0]    RST_LOAD   = CNT_W'(RST_CYCLES - 1);
    localparam logic [SEL_BITS:0]   NUM_SEL    = (SEL_BITS + 1)'(NUM_DESIGNS);
    localparam logic [NUM_DESIGNS-1:0] EN_ONE  = NUM_DESIGNS'(1);

    state_t                  r_state;
    logic [SEL_BITS-1:0]     r_cur;
    logic [SEL_BITS-1:0]     r_target;
    logic [CNT_W-1:0]        r_cnt;
    logic [NUM_DESIGNS-1:0]  r_clk_en;

    state_t                  w_state_nxt;
    logic [SEL_BITS-1:0]     w_cur_nxt;
    logic [SEL_BITS-1:0]     w_target_nxt;
    logic [CNT_W-1:0]        w_cnt_nxt;
    logic [NUM_DESIGNS-1:0]  w_clk_en_nxt;
    logic                    w_sel_valid;
    logic                    w_sel_change;
    logic [NUM_DESIGNS-1:0]              w_proj_rst_n;
    logic [NUM_DESIGNS*INPUT_BITS-1:0]   w_proj_in;

    // Out-of-range selects are dropped so a bad pad setting cannot start a handover.
    assign w_sel_valid  = ({1'b0, sel} < NUM_SEL);
    assign w_sel_change = (sel != r_cur) && w_sel_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_RESET;
            r_cur    <= '0;
            r_target <= '0;
            r_cnt    <= RST_LOAD;
            r_clk_en <= EN_ONE;
        end else begin
            r_state  <= w_state_nxt;
            r_cur    <= w_cur_nxt;
            r_target <= w_target_nxt;
            r_cnt    <= w_cnt_nxt;
            r_clk_en <= w_clk_en_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_cur_nxt    = r_cur;
        w_target_nxt = r_target;
        w_cnt_nxt    = r_cnt;
        w_clk_en_nxt = r_clk_en;
        case (r_state)
            ST_RUN: begin
                if (w_sel_change) begin
                    w_state_nxt  = ST_DRAIN;
                    w_target_nxt = sel;
                    w_cnt_nxt    = DRAIN_LOAD;
                end
            end
            ST_DRAIN: begin
                if (r_cnt == '0) begin
                    w_state_nxt  = ST_SWITCH;
                    w_clk_en_nxt = '0;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            ST_SWITCH: begin
                w_state_nxt  = ST_RESET;
                w_cur_nxt    = r_target;
                w_clk_en_nxt = EN_ONE << r_target;
                w_cnt_nxt    = RST_LOAD;
            end
            ST_RESET: begin
                if (r_cnt == '0) begin
                    w_state_nxt = ST_RUN;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            default: begin
                w_state_nxt  = ST_RESET;
                w_cur_nxt    = '0;
                w_target_nxt = '0;
                w_cnt_nxt    = RST_LOAD;
                w_clk_en_nxt = EN_ONE;
            end
        endcase
    end

    // Enables only move on a rising edge while clk is high, so OR-gating cannot glitch.
    assign proj_clk = {NUM_DESIGNS{clk}} | ~r_clk_en;

    always_comb begin
        w_proj_rst_n = '0;
        w_proj_in    = '0;
        for (int i = 0; i < NUM_DESIGNS; i++) begin
            if ((r_state == ST_RUN) && (int'(r_cur) == i)) begin
                w_proj_rst_n[i]                       = rst_n_in;
                w_proj_in[i*INPUT_BITS +: INPUT_BITS] = in;
            end
        end
    end

    assign proj_rst_n = w_proj_rst_n;
    assign proj_in    = w_proj_in;
    assign active_sel = r_cur;
    assign busy       = (r_state != ST_RUN);
    assign dbg_state  = r_state;

endmodule

// File: tb/tb_proj_switch_mux.sv
// Bench for proj_switch_mux: per-scenario tasks feeding an expected queue of
// {busy, active_sel, low-phase proj_clk} words, plus clock-edge and glitch monitors.
module tb_proj_switch_mux;

    localparam int ND = 8;
    localparam int SB = 4;
    localparam int IB = 8;
    localparam int DC = 2;
    localparam int RC = 4;
    localparam int EW = 1 + SB + ND;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [SB-1:0]    sel = '0;
    logic             rst_n_in = 1'b1;
    logic [IB-1:0]    in_bus = '0;
    logic [ND-1:0]    proj_clk;
    logic [ND-1:0]    proj_rst_n;
    logic [ND*IB-1:0] proj_in;
    logic [SB-1:0]    active_sel;
    logic             busy;
    logic [1:0]       dbg_state;

    int               checks = 0;
    int               errors = 0;
    logic [EW-1:0]    exp_q[$];
    logic [SB-1:0]    sel_sched[16];

    logic             mon_en = 1'b0;
    logic [ND-1:0]    en_lo = '0;
    logic [ND-1:0]    pclk_prev = '1;
    int               rst_edges[ND];
    int               glitch_checks = 0;
    int               glitch_errs = 0;

    proj_switch_mux #(
        .NUM_DESIGNS(ND), .SEL_BITS(SB), .INPUT_BITS(IB),
        .DRAIN_CYCLES(DC), .RST_CYCLES(RC)
    ) dut (
        .clk(clk), .rst(rst), .sel(sel), .rst_n_in(rst_n_in), .in(in_bus),
        .proj_clk(proj_clk), .proj_rst_n(proj_rst_n), .proj_in(proj_in),
        .active_sel(active_sel), .busy(busy), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation still running at %0t", $time);
        $fatal(1, "timeout");
    end

    // Enabled bits are the ones pulled low during the clk low phase.
    always @(negedge clk) begin
        #1;
        en_lo = ~proj_clk;
    end

    initial for (int i = 0; i < ND; i++) rst_edges[i] = 0;

    always @(posedge clk) begin
        if (mon_en) begin
            for (int i = 0; i < ND; i++) begin
                if (en_lo[i] && proj_rst_n[i] === 1'b0) rst_edges[i] = rst_edges[i] + 1;
            end
        end
    end

    // Every proj_clk transition must track clk itself; anything else is a glitch.
    always @(proj_clk) begin
        if (mon_en) begin
            for (int i = 0; i < ND; i++) begin
                if (proj_clk[i] !== pclk_prev[i]) begin
                    glitch_checks++;
                    if (proj_clk[i] !== clk) begin
                        glitch_errs++;
                        $display("FAIL glitch bit %0d at %0t: proj_clk=%b clk=%b", i, $time, proj_clk[i], clk);
                    end
                end
            end
        end
        pclk_prev = proj_clk;
    end

    function automatic logic [EW-1:0] mk_exp(input logic b, input int act, input int en_idx);
        logic [ND-1:0] pm;
        pm = '1;
        if (en_idx >= 0) pm[en_idx] = 1'b0;
        return {b, SB'(act), pm};
    endfunction

    task automatic test_reset();
        logic [EW-1:0] e;
        logic [EW-1:0] g;
        int base;
        rst = 1'b1; sel = '0; rst_n_in = 1'b1; in_bus = '0;
        for (int k = 0; k < 3; k++) begin
            exp_q.push_back(mk_exp(1'b1, 0, 0));
            @(posedge clk); @(negedge clk); #1;
            mon_en = 1'b1;
            g = {busy, active_sel, proj_clk};
            e = exp_q.pop_front();
            checks++;
            if (g !== e || proj_rst_n !== '0 || proj_in !== '0) begin
                errors++;
                $display("FAIL reset_hold cyc %0d: got %h rst_n=%h in=%h, want %h rst_n=0 in=0", k, g, proj_rst_n, proj_in, e);
            end
        end
        rst = 1'b0;
        base = rst_edges[0];
        for (int k = 0; k < RC; k++) exp_q.push_back(mk_exp(k < RC - 1, 0, 0));
        for (int k = 0; k < RC; k++) begin
            @(posedge clk); @(negedge clk); #1;
            g = {busy, active_sel, proj_clk};
            e = exp_q.pop_front();
            checks++;
            if (g !== e) begin
                errors++;
                $display("FAIL startup edge %0d: got %h, want %h", k + 1, g, e);
            end
        end
        checks++;
        if (rst_edges[0] - base !== RC) begin
            errors++;
            $display("FAIL startup_rst_edges: got %0d, want %0d", rst_edges[0] - base, RC);
        end
        in_bus = 8'hA5; rst_n_in = 1'b1;
        #1;
        checks++;
        if (proj_in !== {{(ND-1)*IB{1'b0}}, 8'hA5} || proj_rst_n !== ND'(1)) begin
            errors++;
            $display("FAIL run_route0: got in=%h rst_n=%b, want in=a5 rst_n=00000001", proj_in, proj_rst_n);
        end
        rst_n_in = 1'b0;
        #1;
        checks++;
        if (proj_rst_n !== '0) begin
            errors++;
            $display("FAIL run_rst_follow: got %b, want 00000000", proj_rst_n);
        end
        rst_n_in = 1'b1;
    endtask

    task automatic handover(input string name, input int old_p, input int new_p);
        logic [EW-1:0]    e;
        logic [EW-1:0]    g;
        logic [ND*IB-1:0] exp_in;
        int n;
        int c_old;
        int c_new;
        n = DC + 1 + RC;
        c_old = rst_edges[old_p];
        c_new = rst_edges[new_p];
        for (int k = 0; k <= n; k++) begin
            if (k < DC)       exp_q.push_back(mk_exp(1'b1, old_p, old_p));
            else if (k == DC) exp_q.push_back(mk_exp(1'b1, old_p, -1));
            else if (k < n)   exp_q.push_back(mk_exp(1'b1, new_p, new_p));
            else              exp_q.push_back(mk_exp(1'b0, new_p, new_p));
        end
        rst_n_in = 1'b1;
        for (int k = 0; k <= n; k++) begin
            sel = sel_sched[k];
            @(posedge clk); @(negedge clk); #1;
            g = {busy, active_sel, proj_clk};
            e = exp_q.pop_front();
            checks++;
            if (g !== e) begin
                errors++;
                $display("FAIL %s edge %0d: got %h, want %h", name, k, g, e);
            end
        end
        checks++;
        if (rst_edges[old_p] - c_old !== DC || rst_edges[new_p] - c_new !== RC) begin
            errors++;
            $display("FAIL %s_edges: got old=%0d new=%0d, want old=%0d new=%0d", name,
                     rst_edges[old_p] - c_old, rst_edges[new_p] - c_new, DC, RC);
        end
        in_bus = IB'($urandom_range(1, 255));
        #1;
        exp_in = '0;
        exp_in[new_p*IB +: IB] = in_bus;
        checks++;
        if (proj_in !== exp_in || proj_rst_n !== (ND'(1) << new_p)) begin
            errors++;
            $display("FAIL %s_route: got in=%h rst_n=%b, want in=%h", name, proj_in, proj_rst_n, exp_in);
        end
    endtask

    task automatic test_switch();
        for (int k = 0; k < 16; k++) sel_sched[k] = 4'd3;
        handover("switch_0_3", 0, 3);
    endtask

    task automatic test_invalid();
        logic [EW-1:0] e;
        logic [EW-1:0] g;
        for (int k = 0; k < 10; k++) begin
            sel = (k < 5) ? 4'd9 : 4'd8;
            exp_q.push_back(mk_exp(1'b0, 3, 3));
            @(posedge clk); @(negedge clk); #1;
            g = {busy, active_sel, proj_clk};
            e = exp_q.pop_front();
            checks++;
            if (g !== e) begin
                errors++;
                $display("FAIL invalid_sel %0d cyc %0d: got %h, want %h", sel, k, g, e);
            end
        end
        sel = 4'd3;
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 16; k++) sel_sched[k] = 4'd0;
        handover("switch_3_0", 3, 0);
        for (int k = 0; k < 16; k++) sel_sched[k] = 4'd3;
        sel_sched[1] = 4'd5;
        for (int k = 4; k < 8; k++) sel_sched[k] = 4'd5;
        handover("mid_sel_0_3", 0, 3);
        for (int k = 0; k < 16; k++) sel_sched[k] = 4'd5;
        handover("queued_3_5", 3, 5);
    endtask

    task automatic test_reset_mid();
        logic [EW-1:0] e;
        logic [EW-1:0] g;
        for (int k = 0; k < 16; k++) sel_sched[k] = 4'd2;
        handover("switch_5_2", 5, 2);
        exp_q.push_back(mk_exp(1'b1, 2, 2));
        exp_q.push_back(mk_exp(1'b1, 2, 2));
        exp_q.push_back(mk_exp(1'b1, 2, -1));
        exp_q.push_back(mk_exp(1'b1, 0, 0));
        for (int k = 0; k < RC - 1; k++) exp_q.push_back(mk_exp(1'b1, 0, 0));
        exp_q.push_back(mk_exp(1'b0, 0, 0));
        sel = 4'd6;
        for (int k = 0; k < 4 + RC; k++) begin
            if (k == 3) begin
                rst = 1'b1;
                sel = 4'd0;
            end else if (k == 4) begin
                rst = 1'b0;
            end
            @(posedge clk); @(negedge clk); #1;
            g = {busy, active_sel, proj_clk};
            e = exp_q.pop_front();
            checks++;
            if (g !== e || (k == 3 && proj_rst_n !== '0)) begin
                errors++;
                $display("FAIL reset_mid edge %0d: got %h rst_n=%b, want %h", k, g, proj_rst_n, e);
            end
        end
    endtask

    initial begin
        test_reset();
        test_switch();
        test_invalid();
        test_back_to_back();
        test_reset_mid();
        repeat (2) @(posedge clk);
        checks++;
        if (glitch_errs !== 0 || glitch_checks == 0) begin
            errors++;
            $display("FAIL glitch_monitor: got %0d glitches over %0d transitions, want 0 glitches", glitch_errs, glitch_checks);
        end
        checks++;
        if (exp_q.size() !== 0) begin
            errors++;
            $display("FAIL queue_drain: got %0d leftover, want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/proj_switch_mux.md
# proj_switch_mux

Sequenced successor to the multi-project input multiplexer: routes the shared clock, project reset and input bus to one of NUM_DESIGNS projects. A selection change runs a fixed handover instead of switching instantly:
- drain the outgoing project under reset;
- park all project clocks for one cycle;
- hold the incoming project in reset for RST_CYCLES clocked cycles before releasing it.

Sits between the top-level pad/logic-analyser inputs and the project array.

## Interface
- NUM_DESIGNS, 8, number of selectable projects
- SEL_BITS, 3, select width; must be >= clog2(NUM_DESIGNS)
- INPUT_BITS, 8, per-project input bus width
- DRAIN_CYCLES, 2, cycles the outgoing project stays clocked with reset asserted; >= 1
- RST_CYCLES, 4, cycles the incoming project is clocked with reset asserted; >= 1
- clk  input  1  system clock; single clock domain
- rst  input  1  synchronous, active-high reset
- sel  input  SEL_BITS  requested project
- rst_n_in  input  1  external active-low project reset, forwarded to the active project in RUN
- in  input  INPUT_BITS  shared input bus
- proj_clk  output  NUM_DESIGNS  gated clocks; inactive bits parked high
- proj_rst_n  output  NUM_DESIGNS  per-project active-low reset
- proj_in  output  NUM_DESIGNS*INPUT_BITS  per-project inputs; slice i at [i*INPUT_BITS +: INPUT_BITS]
- active_sel  output  SEL_BITS  currently owned project (cur)
- busy  output  1  high in any state other than RUN

## Operation
Registers:
- state ∈ {RUN, DRAIN, SWITCH, RESET}
- cur, target (SEL_BITS)
- cnt (wide enough for max(DRAIN_CYCLES, RST_CYCLES)-1)
- clk_en (NUM_DESIGNS, one-hot or zero)

Gating and routing:
- proj_clk[i] = clk | ~clk_en[i]. clk_en only changes at posedge, while clk is high, so the gated clocks are glitch-free.
- proj_in slice cur = in only when state==RUN; all other slices, and slice cur outside RUN, = 0.
- proj_rst_n[cur] = rst_n_in in RUN, 0 otherwise. proj_rst_n[i != cur] = 0 always.
- outputs are combinational from the registers; in and rst_n_in pass straight through in RUN.

State transitions (all at posedge):
- rst=1 → state=RESET, cur=0, target=0, cnt=RST_CYCLES-1, clk_en=one-hot(0). Reloaded every cycle rst stays high.
- RUN: if sel != cur and sel < NUM_DESIGNS → DRAIN, target=sel, cnt=DRAIN_CYCLES-1. sel >= NUM_DESIGNS is ignored; the block stays in RUN.
- DRAIN: cur stays clocked, reset asserted, inputs zero. cnt==0 → SWITCH, clk_en=0; else cnt--.
- SWITCH: one cycle, no project clocked. → RESET, cur=target, clk_en=one-hot(target), cnt=RST_CYCLES-1.
- RESET: cur clocked, reset asserted, inputs zero. cnt==0 → RUN; else cnt--.

Boundary rules:
- sel is sampled only in RUN. Changes during DRAIN/SWITCH/RESET are ignored until RUN is re-entered, then evaluated normally. If sel is back at the old value by then, no further switch occurs.
- sel == cur in RUN: no action.
- rst mid-handover aborts it immediately. Any project other than 0 loses its clock at that edge.

## Timing
Reset outputs (edge after rst sampled high):
- state=RESET, busy=1, active_sel=0
- proj_clk[0]=clk, all other proj_clk bits=1
- proj_rst_n=all 0, proj_in=all 0

Startup: RUN is entered RST_CYCLES edges after the first edge with rst=0.

Switch latency, counted from the first RUN edge seeing a valid new sel:
- DRAIN for DRAIN_CYCLES cycles;
- SWITCH for 1 cycle;
- RESET for RST_CYCLES cycles;
- RUN at edge DRAIN_CYCLES+1+RST_CYCLES (7 with defaults).

Clock counts per switch:
- outgoing project gets exactly DRAIN_CYCLES rising edges with reset low after leaving RUN;
- incoming project gets exactly RST_CYCLES rising edges with reset low before release.

active_sel updates at the SWITCH→RESET edge. busy falls at the RESET→RUN edge.

## Test plan
- Reset, defaults: hold rst 3 cycles then release → proj_rst_n[0] low for 4 edges. RUN, busy=0, active_sel=0. proj_rst_n[0] follows rst_n_in; proj_in slice 0 follows in=0xA5, others 0.
- Switch 0→3: sel=3 in RUN. Then:
  - project 0 sees 2 clock edges with reset low, then proj_clk[0] stays high;
  - one cycle with all proj_clk high;
  - project 3 sees 4 edges with reset low;
  - RUN at edge 7, active_sel=3, slice 3 = in.
- Mid-switch sel changes: during DRAIN of a 0→3 switch, drive sel=5 then sel=3 → switch completes to 3 with no extra delay. Then drive sel=5 during RESET of that switch → second switch to 5 starts at the first RUN edge.
- Invalid select: sel=9 with NUM_DESIGNS=8, then sel=8 → block stays in RUN on the current project, busy stays 0.
- Reset mid-handover: assert rst during SWITCH of a 2→6 switch → the following edge gives active_sel=0 and proj_clk[6] parked high. Full startup sequence repeats.
- Glitch check: on every proj_clk bit, across all scenarios → no high pulse shorter than clk high time and no low pulse while the bit is disabled. At most one bit of clk_en is set at any time.
